accel_sample_assembler: RTL and testbench
=========================================

ACCEL_SAMPLE_ASSEMBLER -- requirements
Module: accel_sample_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between bytes of a partial sample before it is discarded (legal range 2..65535).
REQ-002 Parameter CNT_WIDTH, default 16: width of sample_count.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 resp_tdata  input  16  SPI read response word; bits [7:0] carry the register byte, bits [15:8] are ignored.
REQ-006 resp_tvalid  input  1  response word valid.
REQ-007 resp_tready  output  1  block accepts a response word.
REQ-008 resp_tuser  input  1  high marks the first byte (DATAX0) of a six-byte burst.
REQ-009 sample_tdata  output  48  assembled sample {Z[15:0], Y[15:0], X[15:0]}.
REQ-010 sample_tvalid  output  1  sample valid.
REQ-011 sample_tready  input  1  downstream accepts sample.
REQ-012 sample_tlast  output  1  constant 1 (one beat per sample).
REQ-013 sample_count  output  CNT_WIDTH  number of samples handed off downstream, wraps to 0 after all-ones.
REQ-014 drop_count  output  8  number of discarded partial samples, saturates at 255.
REQ-015 timeout_pulse  output  1  one-cycle pulse when a partial sample is discarded by timeout.

Function
REQ-016 A word transfers on the input when resp_tvalid && resp_tready; a sample transfers on the output when sample_tvalid && sample_tready.
REQ-017 The state machine SHALL have exactly two states, COLLECT and OUTPUT; resp_tready = 1 in COLLECT, 0 in OUTPUT.
REQ-018 COLLECT holds a byte index 0..5, where 0..5 map to X0, X1, Y0, Y1, Z0, Z1; each accepted byte is written to its slot and the index increments.
REQ-019 Byte placement: X = {X1, X0}, Y = {Y1, Y0}, Z = {Z1, Z0}, with the low register byte in the low bits.
REQ-020 An accepted word with resp_tuser=1 SHALL always be stored as X0 and set the index to 1; if the index was 1..5, the partial sample is discarded and drop_count increments.
REQ-021 An accepted word with resp_tuser=0 at index 0 SHALL be discarded, leave the index at 0, and increment drop_count.
REQ-022 Accepting Z1 (index 5) in cycle N: the state is OUTPUT and sample_tvalid=1 with the full sample in cycle N+1, and the index is 0.
REQ-023 In OUTPUT, sample_tdata and sample_tvalid hold stable until handshake; on handshake the block returns to COLLECT the next cycle and sample_count increments.
REQ-024 Input and output are never both ready in the same cycle, so no simultaneous input/output transfer is possible.
REQ-025 Timeout counter: cleared on every accepted byte and whenever the index is 0; it increments each COLLECT cycle with index 1..5 and no accepted byte.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1 in COLLECT with no accepted byte that cycle, the next cycle SHALL have index 0, counter 0, timeout_pulse=1 for that single cycle, and drop_count +1.
REQ-027 An accepted byte in the same cycle as timeout expiry SHALL take priority: no timeout occurs and the byte is processed normally.
REQ-028 The timeout counter does not run in OUTPUT; downstream backpressure never causes a drop.
REQ-029 drop_count SHALL saturate at 255 and never wrap.

Reset
REQ-030 When reset=1 at a clock edge, the next state is COLLECT and the following values are forced, overriding any in-flight transfer: index 0, timeout counter 0, sample_tvalid 0, sample_tdata 0, sample_count 0, drop_count 0, timeout_pulse 0.
REQ-031 resp_tready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 A reset asserted during OUTPUT drops the pending sample without incrementing any counter.

Verification
REQ-033 Burst 0x32,0x01,0xFE,0xFF,0x10,0x00 (first byte tuser=1), sample_tready=1 -> one beat with sample_tdata=48'h0010_FFFE_0132; sample_count=1; valid appears exactly 1 cycle after the 6th byte.
REQ-034 sample_tready=0 for 20 cycles after a complete sample -> tdata/tvalid stable, resp_tready=0 throughout, no drop; then tready=1 -> single transfer and resp_tready=1 the next cycle.
REQ-035 Three bytes, then a word with tuser=1, then 5 more bytes -> drop_count=1 and the sample contains only the new burst.
REQ-036 TIMEOUT_CYCLES=8: two bytes then idle -> timeout_pulse exactly one cycle, 8 cycles after the 2nd byte, drop_count=1, no sample; a byte arriving on the expiry cycle -> no timeout.
REQ-037 Word with tuser=0 when idle -> discarded, drop_count=1; 300 such words -> drop_count=255.
REQ-038 Reset asserted during OUTPUT and during index 3 -> all outputs return to reset values in the next cycle, and a following clean burst produces a correct sample with sample_count=1.

Source files
------------

// File: rtl/accel_sample_assembler.sv
`default_nettype none
// ============================================================================
// accel_sample_assembler : packs six SPI register bytes into one X/Y/Z sample
// Revision: 1.0
// ============================================================================
module accel_sample_assembler #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          resp_tdata,
    input  logic                 resp_tvalid,
    output logic                 resp_tready,
    input  logic                 resp_tuser,
    output logic [47:0]          sample_tdata,
    output logic                 sample_tvalid,
    input  logic                 sample_tready,
    output logic                 sample_tlast,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [7:0]           drop_count,
    output logic                 timeout_pulse
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    localparam int             TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     IDX_LAST = 3'd5;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [47:0]          data_q, data_d;
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
    logic [7:0]           dcnt_q, dcnt_d;
    logic                 pulse_q, pulse_d;
    logic                 w_accept;
    logic                 w_drop;
    logic [7:0]           w_byte;
    logic                 w_unused_hi;

    assign w_byte      = resp_tdata[7:0];
    assign w_unused_hi = ^resp_tdata[15:8];
    assign w_accept    = resp_tvalid && (state_q == COLLECT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        pulse_d = 1'b0;
        w_drop  = 1'b0;

        if (state_q == COLLECT) begin
            if (w_accept) begin
                tmo_d = '0;
                if (resp_tuser) begin
                    // A burst start always resynchronises, abandoning any partial sample
                    data_d[7:0] = w_byte;
                    idx_d       = 3'd1;
                    w_drop      = (idx_q != 3'd0);
                end else if (idx_q == 3'd0) begin
                    w_drop = 1'b1;
                end else begin
                    data_d[{idx_q, 3'b000} +: 8] = w_byte;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 3'd0;
                        state_d = OUTPUT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end else if (idx_q == 3'd0) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                idx_d   = 3'd0;
                pulse_d = 1'b1;
                w_drop  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
            if (sample_tready) begin
                state_d = COLLECT;
                scnt_d  = scnt_q + 1'b1;
            end
        end

        if (w_drop && (dcnt_q != 8'hFF)) begin
            dcnt_d = dcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            scnt_q  <= '0;
            dcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign resp_tready   = (state_q == COLLECT);
    assign sample_tvalid = (state_q == OUTPUT);
    assign sample_tdata  = data_q;
    assign sample_tlast  = 1'b1;
    assign sample_count  = scnt_q;
    assign drop_count    = dcnt_q;
    assign timeout_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_sample_assembler.sv
`default_nettype none
// ============================================================================
// tb_accel_sample_assembler : scoreboard bench with directed and random traffic
// Revision: 1.0
// ============================================================================
module tb_accel_sample_assembler;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] resp_tdata;
    logic        resp_tvalid;
    logic        resp_tready;
    logic        resp_tuser;
    logic [47:0] sample_tdata;
    logic        sample_tvalid;
    logic        sample_tready;
    logic        sample_tlast;
    logic [15:0] sample_count;
    logic [7:0]  drop_count;
    logic        timeout_pulse;

    always #5 clk = ~clk;

    accel_sample_assembler #(
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .resp_tdata   (resp_tdata),
        .resp_tvalid  (resp_tvalid),
        .resp_tready  (resp_tready),
        .resp_tuser   (resp_tuser),
        .sample_tdata (sample_tdata),
        .sample_tvalid(sample_tvalid),
        .sample_tready(sample_tready),
        .sample_tlast (sample_tlast),
        .sample_count (sample_count),
        .drop_count   (drop_count),
        .timeout_pulse(timeout_pulse)
    );

    // Reference model: bytes of the partial sample in arrival order
    logic [7:0]  part[$];
    logic [47:0] exp_q[$];
    int          idle;
    bit          pend;
    logic [47:0] pend_data;
    int          m_drops;
    int          m_samples;
    bit          m_pulse;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic note_drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic model_step();
        if (reset) begin
            if (pend) void'(exp_q.pop_back());
            part.delete();
            idle = 0; pend = 0; m_drops = 0; m_samples = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (pend) begin
                if (sample_tready) begin
                    pend = 0;
                    m_samples++;
                end
            end else if (resp_tvalid) begin
                idle = 0;
                if (resp_tuser) begin
                    if (part.size() != 0) note_drop();
                    part.delete();
                    part.push_back(resp_tdata[7:0]);
                end else if (part.size() == 0) begin
                    note_drop();
                end else begin
                    part.push_back(resp_tdata[7:0]);
                    if (part.size() == 6) begin
                        pend_data = {part[5], part[4], part[3], part[2], part[1], part[0]};
                        exp_q.push_back(pend_data);
                        pend = 1;
                        part.delete();
                    end
                end
            end else if (part.size() != 0) begin
                if (idle == T - 1) begin
                    note_drop();
                    part.delete();
                    idle = 0;
                    m_pulse = 1;
                end else begin
                    idle++;
                end
            end else begin
                idle = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare state after the edge
    task automatic cycle(input bit v, input logic [7:0] b, input bit u, input bit rdy, input bit rst);
        resp_tvalid   = v;
        resp_tdata    = {8'($urandom), b};
        resp_tuser    = u;
        sample_tready = rdy;
        reset         = rst;
        model_step();
        @(posedge clk);
        #2;
        chk("resp_tready", resp_tready, !pend);
        chk("sample_tvalid", sample_tvalid, pend);
        if (pend) chk("sample_tdata_hold", sample_tdata, pend_data);
        chk("timeout_pulse", timeout_pulse, m_pulse);
        chk("drop_count", drop_count, m_drops);
        chk("sample_count", sample_count, m_samples % 65536);
        chk("sample_tlast", sample_tlast, 1);
    endtask

    task automatic send_burst(input logic [47:0] bytes_le, input bit rdy);
        for (int i = 0; i < 6; i++) cycle(1, bytes_le[8*i +: 8], (i == 0), rdy, 0);
    endtask

    task automatic do_reset();
        cycle(0, 8'h00, 0, 0, 1);
        chk("reset_tdata", sample_tdata, 0);
        chk("reset_tvalid", sample_tvalid, 0);
        chk("reset_tready", resp_tready, 1);
        chk("reset_sample_count", sample_count, 0);
        chk("reset_drop_count", drop_count, 0);
        chk("reset_pulse", timeout_pulse, 0);
    endtask

    // Monitor: a handshake at the coming edge must match the oldest expected sample
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (sample_tvalid === 1'b1 && sample_tready === 1'b1 && reset === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sample_unexpected actual=%0h required=none", sample_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_sample", sample_tdata, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_at;
        int pulses;
        int gap;
        bit v;
        bit u;
        checks = 0; failures = 0;
        idle = 0; pend = 0; m_drops = 0; m_samples = 0; m_pulse = 0;
        resp_tvalid = 0; resp_tdata = 0; resp_tuser = 0; sample_tready = 0; reset = 1;

        do_reset();
        do_reset();

        // Reference burst with immediate acceptance downstream
        send_burst(48'h0010_FFFE_0132, 1);
        chk("burst_valid_latency", sample_tvalid, 1);
        chk("burst_tdata", sample_tdata, 48'h0010_FFFE_0132);
        cycle(0, 8'h00, 0, 1, 0);
        chk("burst_sample_count", sample_count, 1);

        // Backpressure for 20 cycles, with input offered the whole time
        send_burst(48'hA1B2_C3D4_E5F6, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'($urandom), 1'($urandom), 0, 0);
            chk("bp_tdata", sample_tdata, 48'hA1B2_C3D4_E5F6);
            chk("bp_tready", resp_tready, 0);
        end
        chk("bp_no_drop", drop_count, 0);
        cycle(0, 8'h00, 0, 1, 0);
        chk("bp_tready_after", resp_tready, 1);
        chk("bp_sample_count", sample_count, 2);

        // Resync: three bytes then a new burst start
        do_reset();
        cycle(1, 8'h11, 1, 1, 0);
        cycle(1, 8'h22, 0, 1, 0);
        cycle(1, 8'h33, 0, 1, 0);
        send_burst(48'h6655_4433_2211, 0);
        chk("resync_drop", drop_count, 1);
        chk("resync_tdata", sample_tdata, 48'h6655_4433_2211);
        cycle(0, 8'h00, 0, 1, 0);

        // Timeout: two bytes then idle
        do_reset();
        cycle(1, 8'h01, 1, 1, 0);
        cycle(1, 8'h02, 0, 1, 0);
        seen_at = -1; pulses = 0;
        for (int j = 1; j <= 12; j++) begin
            cycle(0, 8'h00, 0, 1, 0);
            if (timeout_pulse) begin
                pulses++;
                if (seen_at < 0) seen_at = j;
            end
        end
        chk("timeout_latency", seen_at, 8);
        chk("timeout_pulse_count", pulses, 1);
        chk("timeout_drop", drop_count, 1);
        chk("timeout_no_sample", sample_tvalid, 0);

        // A byte landing on the expiry cycle wins over the timeout
        cycle(1, 8'h01, 1, 1, 0);
        cycle(1, 8'h02, 0, 1, 0);
        for (int j = 0; j < 7; j++) cycle(0, 8'h00, 0, 1, 0);
        cycle(1, 8'h03, 0, 1, 0);
        chk("expiry_byte_no_pulse", timeout_pulse, 0);
        chk("expiry_byte_no_drop", drop_count, 1);
        cycle(1, 8'h04, 0, 1, 0);
        cycle(1, 8'h05, 0, 1, 0);
        cycle(1, 8'h06, 0, 1, 0);
        chk("expiry_sample", sample_tdata, 48'h0605_0403_0201);
        cycle(0, 8'h00, 0, 1, 0);

        // Stray words while idle, including saturation
        do_reset();
        cycle(1, 8'h55, 0, 1, 0);
        chk("stray_drop_one", drop_count, 1);
        for (int i = 0; i < 299; i++) cycle(1, 8'($urandom), 0, 1, 0);
        chk("stray_drop_sat", drop_count, 255);

        // Reset during OUTPUT and during a partial sample
        do_reset();
        send_burst(48'h0123_4567_89AB, 0);
        cycle(0, 8'h00, 0, 1, 1);
        chk("rst_out_tvalid", sample_tvalid, 0);
        chk("rst_out_tdata", sample_tdata, 0);
        chk("rst_out_count", sample_count, 0);
        cycle(1, 8'h10, 1, 1, 0);
        cycle(1, 8'h20, 0, 1, 0);
        cycle(1, 8'h30, 0, 1, 0);
        do_reset();
        send_burst(48'hCAFE_F00D_BEEF, 1);
        chk("rst_clean_tdata", sample_tdata, 48'hCAFE_F00D_BEEF);
        cycle(0, 8'h00, 0, 1, 0);
        chk("rst_clean_count", sample_count, 1);
        chk("rst_clean_drop", drop_count, 0);

        // Randomized traffic with gaps long enough to expire partial samples
        gap = 0;
        for (int i = 0; i < 2000; i++) begin
            if (gap == 0 && $urandom_range(0, 39) == 0) gap = $urandom_range(5, 12);
            if (gap > 0) begin
                gap--;
                v = 0;
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            u = (part.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            cycle(v, 8'($urandom), u, ($urandom_range(0, 2) != 0), ($urandom_range(0, 499) == 0));
        end

        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 1, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
